// File: rtl/cmip_toggle_req_arb.sv
// Synchronizes toggle-encoded requests and arbitrates them onto one valid/ready command port.
// Define CMIP_TOGGLE_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round robin.
module cmip_toggle_req_arb #(
    parameter int CH_NUM    = 4,
    parameter int BUS_DELAY = 2,
    parameter int CH_WDTH   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [CH_NUM-1:0]  i_req_tgl,
    output logic [CH_NUM-1:0]  o_ack_tgl,
    output logic               o_cmd_vld,
    input  logic               i_cmd_rdy,
    output logic [CH_WDTH-1:0] o_cmd_ch,
    output logic [CH_NUM-1:0]  o_pend,
    output logic [CH_NUM-1:0]  o_ovf
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CH_NUM-1:0]  sync_q [BUS_DELAY];
    logic [CH_NUM-1:0]  prev_q;
    logic [CH_NUM-1:0]  pend_q, pend_d;
    logic [CH_NUM-1:0]  ovf_q, ovf_d;
    logic [CH_NUM-1:0]  ack_q, ack_d;
    logic [CH_WDTH-1:0] rr_q, rr_d;
    logic [CH_WDTH-1:0] ch_q, ch_d;
    logic [CH_WDTH-1:0] win;
    logic [CH_NUM-1:0]  edge_w;
    logic [CH_NUM-1:0]  acc_mask;
    logic [CH_NUM-1:0]  pend_sh;
    logic               found;
    logic               acc;
    int                 idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BUS_DELAY; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= i_req_tgl;
            for (int i = 1; i < BUS_DELAY; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[BUS_DELAY-1];
        end
    end

    assign edge_w   = sync_q[BUS_DELAY-1] ^ prev_q;
    assign acc      = (state_q == ST_BUSY) && i_cmd_rdy;
    assign acc_mask = acc ? (CH_NUM'(1) << ch_q) : '0;

    // Search starts at rr; in fixed-priority builds rr never leaves 0.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        pend_sh = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx     = (int'(rr_q) + i) % CH_NUM;
            pend_sh = pend_q >> idx;
            if (!found && pend_sh[0]) begin
                found = 1'b1;
                win   = CH_WDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        ack_d   = ack_q ^ acc_mask;
        pend_d  = (pend_q & ~acc_mask) | edge_w;
        ovf_d   = ovf_q | (edge_w & pend_q & ~acc_mask);
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_BUSY;
                    ch_d    = win;
                end
            end
            ST_BUSY: begin
                if (i_cmd_rdy) begin
                    state_d = ST_IDLE;
`ifdef CMIP_TOGGLE_ARB_FIXED_PRIO_EN
                    rr_d = '0;
`else
                    rr_d = (int'(ch_q) == CH_NUM - 1) ? '0 : ch_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            rr_q    <= '0;
            ack_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_cmd_vld = (state_q == ST_BUSY);
    assign o_cmd_ch  = ch_q;
    assign o_ack_tgl = ack_q;
    assign o_pend    = pend_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_cmip_toggle_req_arb.sv
// Bench for cmip_toggle_req_arb: directed scenarios plus random traffic
// checked against a request-history reference model.
module tb_cmip_toggle_req_arb;

    localparam int N  = 4;
    localparam int BD = 2;
    localparam int W  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         rdy;
    logic [N-1:0] ack;
    logic         vld;
    logic [W-1:0] ch;
    logic [N-1:0] pend;
    logic [N-1:0] ovf;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [N-1:0] m_smp [BD+1];
    logic [N-1:0] m_pend, m_ovf, m_ack;
    int           m_rr, m_ch;
    bit           m_busy;

    cmip_toggle_req_arb #(.CH_NUM(N), .BUS_DELAY(BD), .CH_WDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_tgl(req), .o_ack_tgl(ack),
        .o_cmd_vld(vld), .i_cmd_rdy(rdy), .o_cmd_ch(ch),
        .o_pend(pend), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [N-1:0] p, int base);
        for (int i = 0; i < N; i++) begin
            if (p[(base + i) % N]) return (base + i) % N;
        end
        return -1;
    endfunction

    // m_smp[k] is the request level sampled k edges ago; a request is seen
    // once its level has passed BD samples and differs from the one before.
    function void model_update();
        logic [N-1:0] e, mask;
        int           w;
        if (rst) begin
            for (int k = 0; k <= BD; k++) m_smp[k] = '0;
            m_pend = '0; m_ovf = '0; m_ack = '0;
            m_rr = 0; m_ch = 0; m_busy = 0;
            return;
        end
        e    = m_smp[BD-1] ^ m_smp[BD];
        mask = (m_busy && rdy) ? (4'b0001 << m_ch) : 4'b0000;
        m_ovf = m_ovf | (e & m_pend & ~mask);
        if (m_busy && rdy) begin
            m_ack  = m_ack ^ mask;
            m_busy = 0;
`ifndef CMIP_TOGGLE_ARB_FIXED_PRIO_EN
            m_rr = (m_ch + 1) % N;
`endif
        end else if (!m_busy && m_pend != 0) begin
            w      = pick(m_pend, m_rr);
            m_ch   = w;
            m_busy = 1;
        end
        m_pend = (m_pend & ~mask) | e;
        for (int k = BD; k > 0; k--) m_smp[k] = m_smp[k-1];
        m_smp[0] = req;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rdy = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; rdy = 1'b1;
        step();
        total++;
        if ({vld, ch, ack, pend, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_outs act=%0b/%0d/%h/%h/%h exp=0", vld, ch, ack, pend, ovf);
        end
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; rdy = 1'b1;
        step(); step(); step();
        total++;
        if (vld !== 1'b0 || pend !== 4'b0100) begin
            bad++;
            $display("FAIL single_pend act=vld%0b pend%h exp=vld0 pend4", vld, pend);
        end
        step();
        total++;
        if (vld !== 1'b1 || ch !== 2'd2) begin
            bad++;
            $display("FAIL single_grant act=vld%0b ch%0d exp=vld1 ch2", vld, ch);
        end
        step();
        total++;
        if (ack !== 4'b0100 || pend !== 4'b0 || vld !== 1'b0) begin
            bad++;
            $display("FAIL single_ack act=ack%h pend%h vld%0b exp=ack4 pend0 vld0", ack, pend, vld);
        end
    endtask

    task automatic test_all_channels();
        int g[$];
        int t[$];
        do_reset();
        req = 4'hF; rdy = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (vld) begin g.push_back(int'(ch)); t.push_back(i); end
        end
        total++;
        if (g.size() != 4) begin
            bad++;
            $display("FAIL all_count act=%0d exp=4", g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (g[i] != i || t[i] != 4 + 2 * i) begin
                    bad++;
                    $display("FAIL all_order idx%0d act=ch%0d@%0d exp=ch%0d@%0d", i, g[i], t[i], i, 4 + 2 * i);
                end
            end
        end
        total++;
        if (ack !== 4'hF) begin
            bad++;
            $display("FAIL all_ack act=%h exp=f", ack);
        end
    endtask

    task automatic test_rr_fairness();
        int g[$];
        int e0, e1;
        do_reset();
        req = 4'b0010; rdy = 1'b1;
        repeat (5) step();
        req = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            step();
            if (vld) g.push_back(int'(ch));
        end
`ifdef CMIP_TOGGLE_ARB_FIXED_PRIO_EN
        e0 = 0; e1 = 3;
`else
        e0 = 3; e1 = 0;
`endif
        total++;
        if (g.size() != 2) begin
            bad++;
            $display("FAIL rr_count act=%0d exp=2", g.size());
        end else if (g[0] != e0 || g[1] != e1) begin
            bad++;
            $display("FAIL rr_order act=%0d,%0d exp=%0d,%0d", g[0], g[1], e0, e1);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        do_reset();
        req = 4'b0010; rdy = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (vld !== 1'b1 || ch !== 2'd1 || ack !== 4'b0) begin
                bad++;
                $display("FAIL bp_hold cyc%0d act=vld%0b ch%0d ack%h exp=vld1 ch1 ack0", i, vld, ch, ack);
            end
        end
        rdy = 1'b1;
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            if (vld) hs++;
            step();
        end
        total++;
        if (hs != 1 || ack !== 4'b0010) begin
            bad++;
            $display("FAIL bp_release act=hs%0d ack%h exp=hs1 ack2", hs, ack);
        end
    endtask

    task automatic test_overflow();
        int cmds;
        do_reset();
        req = 4'b0010; rdy = 1'b0;
        repeat (6) step();
        req = 4'b0000;
        repeat (6) step();
        total++;
        if (ovf !== 4'b0010 || vld !== 1'b1 || ch !== 2'd1 || pend !== 4'b0010) begin
            bad++;
            $display("FAIL ovf_set act=ovf%h vld%0b ch%0d pend%h exp=ovf2 vld1 ch1 pend2", ovf, vld, ch, pend);
        end
        rdy = 1'b1;
        cmds = 0;
        for (int i = 0; i < 6; i++) begin
            if (vld) cmds++;
            step();
        end
        total++;
        if (cmds != 1 || ack !== 4'b0010 || ovf !== 4'b0010) begin
            bad++;
            $display("FAIL ovf_once act=cmds%0d ack%h ovf%h exp=cmds1 ack2 ovf2", cmds, ack, ovf);
        end
    endtask

    task automatic test_simul_accept();
        do_reset();
        req = 4'b0010; rdy = 1'b0;
        repeat (4) step();
        req = 4'b0000;
        step(); step();
        rdy = 1'b1;
        step();
        total++;
        if (ack !== 4'b0010 || pend !== 4'b0010 || ovf !== 4'b0 || vld !== 1'b0) begin
            bad++;
            $display("FAIL simul_acc act=ack%h pend%h ovf%h vld%0b exp=ack2 pend2 ovf0 vld0", ack, pend, ovf, vld);
        end
        step();
        total++;
        if (vld !== 1'b1 || ch !== 2'd1) begin
            bad++;
            $display("FAIL simul_regrant act=vld%0b ch%0d exp=vld1 ch1", vld, ch);
        end
        step();
        total++;
        if (ack !== 4'b0000 || pend !== 4'b0) begin
            bad++;
            $display("FAIL simul_ack2 act=ack%h pend%h exp=ack0 pend0", ack, pend);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        req = 4'b0100; rdy = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        total++;
        if ({vld, ch, ack, pend, ovf} !== '0) begin
            bad++;
            $display("FAIL rstbusy_outs act=%0b/%0d/%h/%h/%h exp=0", vld, ch, ack, pend, ovf);
        end
        rst = 1'b0;
        repeat (4) step();
        total++;
        if (vld !== 1'b1 || ch !== 2'd2 || ack !== 4'b0) begin
            bad++;
            $display("FAIL rstbusy_held act=vld%0b ch%0d ack%h exp=vld1 ch2 ack0", vld, ch, ack);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) req[c] = ~req[c];
            end
            step();
            total++;
            if (vld !== m_busy || (m_busy && ch !== W'(m_ch)) || ack !== m_ack
                || pend !== m_pend || ovf !== m_ovf) begin
                bad++;
                $display("FAIL rand cyc%0d act=v%0b c%0d a%h p%h o%h exp=v%0b c%0d a%h p%h o%h",
                         i, vld, ch, ack, pend, ovf, m_busy, m_ch, m_ack, m_pend, m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; rdy = 1'b0;
        test_reset();
        test_single();
        test_all_channels();
        test_rr_fairness();
        test_backpressure();
        test_overflow();
        test_simul_accept();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
